// File: rtl/factorial_scheduler_pkg.sv
// Shared definitions for the factorial scheduler: state encoding and default widths.
package factorial_scheduler_pkg;

  localparam int N_W_DEF   = 8;
  localparam int RES_W_DEF = 17;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/factorial_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; combinational one-hot grant, ptr selects the winner on contention.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic       i_en,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) begin
        o_grant = i_ptr ? 2'b10 : 2'b01;
      end else begin
        o_grant = i_req;
      end
    end
  end

endmodule

// File: rtl/factorial_scheduler.sv
// Two-requester scheduler sharing one iterative, saturating factorial datapath (one multiply per clock).
module factorial_scheduler
  import factorial_scheduler_pkg::*;
#(
  parameter int N_W   = N_W_DEF,
  parameter int RES_W = RES_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [1:0]       i_req,
  input  logic [N_W-1:0]   i_num0,
  input  logic [N_W-1:0]   i_num1,
  output logic [1:0]       o_gnt,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_done_id,
  output logic [RES_W-1:0] o_result,
  output logic             o_ov
);

  localparam int P_W = RES_W + N_W;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rr_ptr;
  logic             r_id;
  logic             r_ov_int;
  logic [RES_W-1:0] r_acc;
  logic [N_W-1:0]   r_idx;
  logic [1:0]       r_gnt;
  logic             r_done;
  logic             r_done_id;
  logic [RES_W-1:0] r_result;
  logic             r_ov;

  logic [1:0]       w_arb_gnt;
  logic             w_arb_en;
  logic             w_pick;
  logic             w_last;
  logic             w_sat;
  logic [P_W-1:0]   w_prod;

  assign w_arb_en = (r_state == S_IDLE) && !i_clr;

  rr_arbiter2 u_arb (
    .i_req   (i_req),
    .i_ptr   (r_rr_ptr),
    .i_en    (w_arb_en),
    .o_grant (w_arb_gnt)
  );

  assign w_pick = w_arb_gnt[1];
  assign w_last = (r_idx <= N_W'(1));
  assign w_prod = P_W'(r_acc) * P_W'(r_idx);
  // Once saturated, the accumulator stays all-ones for the rest of the job.
  assign w_sat  = (w_prod[P_W-1:RES_W] != '0) || r_ov_int;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (|w_arb_gnt) w_state_nxt = S_MUL;
      S_MUL:   if (w_last)     w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_clr) begin
      w_state_nxt = S_IDLE;
    end
  end

  // done is raised on the edge entering DONE so it is visible num cycles after gnt.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr  <= 1'b0;
      r_id      <= 1'b0;
      r_ov_int  <= 1'b0;
      r_acc     <= RES_W'(1);
      r_idx     <= '0;
      r_gnt     <= 2'b00;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_result  <= '0;
      r_ov      <= 1'b0;
    end else begin
      r_gnt  <= w_arb_gnt;
      r_done <= 1'b0;
      if (!i_clr) begin
        case (r_state)
          S_IDLE: begin
            if (|w_arb_gnt) begin
              r_idx    <= w_pick ? i_num1 : i_num0;
              r_acc    <= RES_W'(1);
              r_id     <= w_pick;
              r_ov_int <= 1'b0;
              r_rr_ptr <= ~w_pick;
            end
          end
          S_MUL: begin
            if (w_last) begin
              r_done    <= 1'b1;
              r_result  <= r_acc;
              r_ov      <= r_ov_int;
              r_done_id <= r_id;
            end else begin
              r_idx <= r_idx - N_W'(1);
              if (w_sat) begin
                r_acc    <= '1;
                r_ov_int <= 1'b1;
              end else begin
                r_acc <= w_prod[RES_W-1:0];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_gnt     = r_gnt;
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = r_done;
  assign o_done_id = r_done_id;
  assign o_result  = r_result;
  assign o_ov      = r_ov;

endmodule

// File: tb/tb_factorial_scheduler.sv
// Scoreboard bench for factorial_scheduler: expected results queued at request time, checked on done.
module tb_factorial_scheduler;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [1:0]  req;
  logic [7:0]  num0;
  logic [7:0]  num1;
  logic [1:0]  gnt;
  logic        busy;
  logic        done;
  logic        done_id;
  logic [16:0] result;
  logic        ov;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic        id;
    logic [16:0] res;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  factorial_scheduler dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_clr     (clr),
    .i_req     (req),
    .i_num0    (num0),
    .i_num1    (num1),
    .o_gnt     (gnt),
    .o_busy    (busy),
    .o_done    (done),
    .o_done_id (done_id),
    .o_result  (result),
    .o_ov      (ov)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic id, input int n);
    exp_t   m;
    longint r;
    logic   o;
    r = 1;
    o = 1'b0;
    for (int i = 2; i <= n; i++) begin
      if (!o) begin
        r = r * i;
        if (r > 131071) o = 1'b1;
      end
    end
    m.id  = id;
    m.res = o ? 17'h1FFFF : r[16:0];
    m.ov  = o;
    return m;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected_done: got id=%0d result=%h ov=%0d, required no done", done_id, result, ov);
      end else begin
        e_mon = sb.pop_front();
        if (done_id !== e_mon.id || result !== e_mon.res || ov !== e_mon.ov) begin
          $display("FAIL sb_result: got id=%0d result=%h ov=%0d, required id=%0d result=%h ov=%0d",
                   done_id, result, ov, e_mon.id, e_mon.res, e_mon.ov);
        end else begin
          n_pass++;
        end
      end
    end
  end

  // Drives one job and measures grant and done latency; returns at the negedge of the done cycle.
  task automatic do_job(input int k, input logic [7:0] n, output logic [1:0] g, output int lat);
    int cyc;
    @(posedge clk); #1;
    if (k == 0) num0 = n; else num1 = n;
    sb.push_back(model(k[0], int'(n)));
    req[k] = 1'b1;
    g   = 2'b00;
    cyc = 0;
    @(negedge clk);
    while (gnt == 2'b00 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    g = gnt;
    @(posedge clk); #1;
    req[k] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 300);
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    logic [1:0] g;
    int lat;
    rst_n = 1'b0; clr = 1'b0; req = 2'b00; num0 = '0; num1 = '0;
    #14 rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (gnt !== 2'b00) $display("FAIL rst_gnt: got %b, required 00", gnt); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b, required 0", done); else n_pass++;
    n_total++; if (done_id !== 1'b0) $display("FAIL rst_done_id: got %b, required 0", done_id); else n_pass++;
    n_total++; if (result !== 17'h0) $display("FAIL rst_result: got %h, required 0", result); else n_pass++;
    n_total++; if (ov !== 1'b0) $display("FAIL rst_ov: got %b, required 0", ov); else n_pass++;
    do_job(0, 8'd5, g, lat);
    n_total++; if (g !== 2'b01) $display("FAIL fact5_gnt: got %b, required 01", g); else n_pass++;
    n_total++; if (lat !== 5) $display("FAIL fact5_latency: got %0d, required 5", lat); else n_pass++;
  endtask

  task automatic test_small_operands();
    logic [1:0] g;
    int lat;
    do_job(0, 8'd0, g, lat);
    n_total++; if (lat !== 1) $display("FAIL fact0_latency: got %0d, required 1", lat); else n_pass++;
    do_job(0, 8'd1, g, lat);
    n_total++; if (lat !== 1) $display("FAIL fact1_latency: got %0d, required 1", lat); else n_pass++;
    do_job(0, 8'd8, g, lat);
    n_total++; if (lat !== 8) $display("FAIL fact8_latency: got %0d, required 8", lat); else n_pass++;
    n_total++; if (result !== 17'd40320) $display("FAIL fact8_result: got %0d, required 40320", result); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [1:0] g;
    int lat;
    do_job(1, 8'd9, g, lat);
    n_total++; if (g !== 2'b10) $display("FAIL fact9_gnt: got %b, required 10", g); else n_pass++;
    n_total++; if (ov !== 1'b1) $display("FAIL fact9_ov: got %b, required 1", ov); else n_pass++;
    do_job(1, 8'd3, g, lat);
    n_total++; if (ov !== 1'b0) $display("FAIL fact3_ov_cleared: got %b, required 0", ov); else n_pass++;
    n_total++; if (result !== 17'd6) $display("FAIL fact3_result: got %0d, required 6", result); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [4];
    int gcnt, dcnt, overlap, early, cyc;
    @(posedge clk); #1;
    rst_n = 1'b0;
    num0 = 8'd2; num1 = 8'd3; req = 2'b11;
    sb.push_back(model(1'b0, 2)); sb.push_back(model(1'b1, 3));
    sb.push_back(model(1'b0, 2)); sb.push_back(model(1'b1, 3));
    @(negedge clk);
    rst_n = 1'b1;
    gcnt = 0; dcnt = 0; overlap = 0; early = 0; cyc = 0;
    while (dcnt < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (gnt != 2'b00 && done) overlap++;
      if (done) dcnt++;
      if (gnt != 2'b00) begin
        if (gcnt != dcnt) early++;
        if (gcnt < 4) seq[gcnt] = gnt;
        gcnt++;
        if (gcnt == 4) req = 2'b00;
      end
    end
    req = 2'b00;
    n_total++; if (gcnt !== 4 || dcnt !== 4) $display("FAIL b2b_counts: got gnt=%0d done=%0d, required 4 and 4", gcnt, dcnt); else n_pass++;
    n_total++; if (seq[0] !== 2'b01 || seq[1] !== 2'b10 || seq[2] !== 2'b01 || seq[3] !== 2'b10)
      $display("FAIL b2b_order: got %b %b %b %b, required 01 10 01 10", seq[0], seq[1], seq[2], seq[3]); else n_pass++;
    n_total++; if (overlap !== 0) $display("FAIL b2b_gnt_done_overlap: got %0d, required 0", overlap); else n_pass++;
    n_total++; if (early !== 0) $display("FAIL b2b_gnt_before_done: got %0d, required 0", early); else n_pass++;
  endtask

  task automatic test_clr();
    logic [1:0] g;
    int lat, cyc, dseen;
    @(posedge clk); #1;
    num0 = 8'd8; req = 2'b01;
    cyc = 0;
    @(negedge clk);
    while (gnt == 2'b00 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    n_total++; if (gnt !== 2'b01) $display("FAIL clr_job_gnt: got %b, required 01", gnt); else n_pass++;
    @(posedge clk); #1; req = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL clr_busy: got %b, required 0", busy); else n_pass++;
    n_total++; if (result !== 17'd6) $display("FAIL clr_result_held: got %0d, required 6", result); else n_pass++;
    dseen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dseen++;
    end
    n_total++; if (dseen !== 0) $display("FAIL clr_no_done: got %0d done pulses, required 0", dseen); else n_pass++;
    do_job(1, 8'd4, g, lat);
    n_total++; if (g !== 2'b10 || lat !== 4) $display("FAIL clr_next_job: got gnt=%b lat=%0d, required gnt=10 lat=4", g, lat); else n_pass++;
  endtask

  task automatic test_async_reset();
    int cyc;
    @(posedge clk); #1;
    num0 = 8'd8; req = 2'b01;
    cyc = 0;
    @(negedge clk);
    while (gnt == 2'b00 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1; req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL async_busy: got %b, required 0", busy); else n_pass++;
    n_total++; if (gnt !== 2'b00 || done !== 1'b0) $display("FAIL async_gnt_done: got gnt=%b done=%b, required 00 0", gnt, done); else n_pass++;
    n_total++; if (result !== 17'h0 || ov !== 1'b0) $display("FAIL async_result_ov: got result=%h ov=%b, required 0 0", result, ov); else n_pass++;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    num0 = 8'd1; num1 = 8'd1; req = 2'b11;
    sb.push_back(model(1'b0, 1));
    cyc = 0;
    @(negedge clk);
    while (gnt == 2'b00 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    n_total++; if (gnt !== 2'b01) $display("FAIL async_rr_ptr: got %b, required 01", gnt); else n_pass++;
    @(posedge clk); #1; req = 2'b00;
    for (int i = 0; i < 8; i++) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_small_operands();
    test_overflow();
    test_back_to_back();
    test_clr();
    test_async_reset();
    n_total++;
    if (sb.size() !== 0) $display("FAIL sb_drain: got %0d pending results, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
